// File: rtl/custom_hls_ctrl_slave.sv
// AXI-lite control slave exposing the ap_ctrl_hs register map, N pointer arguments and a level interrupt.
// Latency: write visible one cycle after the W handshake; read data valid one cycle after the AR handshake.
// Backpressure: bvalid/rvalid hold until bready/rready; awready/arready drop while a transaction is in flight.
module custom_hls_ctrl_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ARGS   = 3,
  parameter int ARG_WIDTH  = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          control_axilite_awvalid,
  output logic                          control_axilite_awready,
  input  logic [ADDR_WIDTH-1:0]         control_axilite_awaddr,
  input  logic                          control_axilite_wvalid,
  output logic                          control_axilite_wready,
  input  logic [DATA_WIDTH-1:0]         control_axilite_wdata,
  input  logic [DATA_WIDTH/8-1:0]       control_axilite_wstrb,
  output logic                          control_axilite_bvalid,
  input  logic                          control_axilite_bready,
  output logic [1:0]                    control_axilite_bresp,
  input  logic                          control_axilite_arvalid,
  output logic                          control_axilite_arready,
  input  logic [ADDR_WIDTH-1:0]         control_axilite_araddr,
  output logic                          control_axilite_rvalid,
  input  logic                          control_axilite_rready,
  output logic [DATA_WIDTH-1:0]         control_axilite_rdata,
  output logic [1:0]                    control_axilite_rresp,
  output logic                          ap_start_o,
  input  logic                          ap_ready_i,
  input  logic                          ap_done_i,
  input  logic                          ap_idle_i,
  output logic [NUM_ARGS*ARG_WIDTH-1:0] args_o,
  output logic                          interrupt_o
);

  localparam int IW = ADDR_WIDTH - 3;
  localparam logic [ADDR_WIDTH-1:0] ARG_BASE = ADDR_WIDTH'(16);
  localparam logic [IW-1:0] ARG_COUNT = IW'(NUM_ARGS);
  localparam bit HAS_HI = (ARG_WIDTH == 64);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  typedef struct packed {
    logic          ctrl;
    logic          gie;
    logic          ier;
    logic          isr;
    logic          arg;
    logic          hi;
    logic [IW-1:0] idx;
  } dec_t;

  // Address bits [1:0] are ignored; args start at 0x10 with an 8-byte stride.
  function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] a);
    dec_t d;
    d = '0;
    d.idx = IW'((a - ARG_BASE) >> 3);
    d.hi = a[2];
    if (a[ADDR_WIDTH-1:4] == '0) begin
      d.ctrl = (a[3:2] == 2'd0);
      d.gie  = (a[3:2] == 2'd1);
      d.ier  = (a[3:2] == 2'd2);
      d.isr  = (a[3:2] == 2'd3);
    end else begin
      d.arg = (d.idx < ARG_COUNT) && (!a[2] || HAS_HI);
    end
    return d;
  endfunction

  function automatic logic is_mapped(input dec_t d);
    return d.ctrl | d.gie | d.ier | d.isr | d.arg;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return r;
  endfunction

  wstate_t w_state, w_next;
  rstate_t r_state, r_next;
  logic [ADDR_WIDTH-1:0] waddr;
  dec_t wdec, rdec;
  logic w_fire, ar_fire;
  logic ap_start, ap_done, ap_ready, auto_restart, gie;
  logic [1:0] ier, isr, isr_d;
  logic [ARG_WIDTH-1:0] args_q [NUM_ARGS];
  logic [ARG_WIDTH-1:0] args_d [NUM_ARGS];
  logic [63:0] arg_word, arg_rd;
  logic [31:0] rval;

  assign wdec    = decode(waddr);
  assign rdec    = decode(control_axilite_araddr);
  assign w_fire  = (w_state == W_DATA) && control_axilite_wvalid;
  assign ar_fire = (r_state == R_IDLE) && control_axilite_arvalid;

  // Write channel next state and handshake outputs.
  always_comb begin
    w_next = w_state;
    control_axilite_awready = 1'b0;
    control_axilite_wready  = 1'b0;
    control_axilite_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        control_axilite_awready = 1'b1;
        if (control_axilite_awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        control_axilite_wready = 1'b1;
        if (control_axilite_wvalid) w_next = W_RESP;
      end
      W_RESP: begin
        control_axilite_bvalid = 1'b1;
        if (control_axilite_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Write channel state, latched address and response code.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state <= W_IDLE;
      waddr <= '0;
      control_axilite_bresp <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      if (control_axilite_awvalid && control_axilite_awready) waddr <= control_axilite_awaddr;
      if (w_fire) control_axilite_bresp <= is_mapped(wdec) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Read channel next state and handshake outputs.
  always_comb begin
    r_next = r_state;
    control_axilite_arready = 1'b0;
    control_axilite_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        control_axilite_arready = 1'b1;
        if (control_axilite_arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        control_axilite_rvalid = 1'b1;
        if (control_axilite_rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read data mux; unmapped addresses read as zero.
  always_comb begin
    arg_rd = '0;
    for (int i = 0; i < NUM_ARGS; i++) begin
      if (rdec.idx == IW'(i)) arg_rd = 64'(args_q[i]);
    end
    rval = '0;
    if (rdec.ctrl)     rval = {24'd0, auto_restart, 3'd0, ap_ready, ap_idle_i, ap_done, ap_start};
    else if (rdec.gie) rval = {31'd0, gie};
    else if (rdec.ier) rval = {30'd0, ier};
    else if (rdec.isr) rval = {30'd0, isr};
    else if (rdec.arg) rval = rdec.hi ? arg_rd[63:32] : arg_rd[31:0];
  end

  // Read channel state; data is captured once at the AR handshake and held while rvalid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= R_IDLE;
      control_axilite_rdata <= '0;
      control_axilite_rresp <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ar_fire) begin
        control_axilite_rdata <= rval;
        control_axilite_rresp <= is_mapped(rdec) ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Argument update with bytewise strobes on the addressed 32-bit half.
  always_comb begin
    args_d = args_q;
    arg_word = '0;
    for (int i = 0; i < NUM_ARGS; i++) begin
      if (w_fire && wdec.arg && (wdec.idx == IW'(i))) begin
        arg_word = 64'(args_q[i]);
        if (wdec.hi) arg_word[63:32] = merge_bytes(arg_word[63:32], control_axilite_wdata, control_axilite_wstrb);
        else         arg_word[31:0]  = merge_bytes(arg_word[31:0], control_axilite_wdata, control_axilite_wstrb);
        args_d[i] = arg_word[ARG_WIDTH-1:0];
      end
    end
  end

  // ISR: write-1-to-toggle, with kernel set events winning over a coincident toggle.
  always_comb begin
    isr_d = isr;
    if (w_fire && wdec.isr && control_axilite_wstrb[0]) isr_d = isr ^ control_axilite_wdata[1:0];
    if (ap_done_i && ier[0]) isr_d[0] = 1'b1;
    if (ap_ready_i && ap_start && ier[1]) isr_d[1] = 1'b1;
  end

  // Control/status registers; kernel set events win over clear-on-read of CTRL.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ap_start <= 1'b0;
      ap_done <= 1'b0;
      ap_ready <= 1'b0;
      auto_restart <= 1'b0;
      gie <= 1'b0;
      ier <= '0;
      isr <= '0;
      args_q <= '{default: '0};
    end else begin
      if (w_fire && wdec.ctrl && control_axilite_wstrb[0] && control_axilite_wdata[0]) ap_start <= 1'b1;
      else if (ap_start && ap_ready_i && !auto_restart) ap_start <= 1'b0;
      if (w_fire && wdec.ctrl && control_axilite_wstrb[0]) auto_restart <= control_axilite_wdata[7];
      if (ap_done_i) ap_done <= 1'b1;
      else if (ar_fire && rdec.ctrl) ap_done <= 1'b0;
      if (ap_ready_i && ap_start) ap_ready <= 1'b1;
      else if (ar_fire && rdec.ctrl) ap_ready <= 1'b0;
      if (w_fire && wdec.gie && control_axilite_wstrb[0]) gie <= control_axilite_wdata[0];
      if (w_fire && wdec.ier && control_axilite_wstrb[0]) ier <= control_axilite_wdata[1:0];
      isr <= isr_d;
      args_q <= args_d;
    end
  end

  for (genvar g = 0; g < NUM_ARGS; g++) begin : g_args
    assign args_o[g*ARG_WIDTH +: ARG_WIDTH] = args_q[g];
  end

  assign ap_start_o  = ap_start;
  assign interrupt_o = gie & (|isr);

endmodule

// File: tb/tb_custom_hls_ctrl_slave.sv
// Self-checking bench for custom_hls_ctrl_slave: directed kernel/interrupt scenarios plus random register traffic.
// Outputs are sampled and inputs driven on the falling edge; the DUT acts on the rising edge.
// A watchdog bounds the run; every handshake wait has a cycle budget.
module tb_custom_hls_ctrl_slave;
  localparam int AW = 12;
  localparam int NA = 3;
  localparam int ARGW = 64;

  logic clk = 1'b0;
  logic rst_i;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic ap_start_o, ap_ready_i, ap_done_i, ap_idle_i, interrupt_o;
  logic [NA*ARGW-1:0] args_o;

  int total = 0;
  int bad = 0;
  int start_cycles = 0;

  logic [63:0] m_args [NA];
  logic m_gie;
  logic [1:0] m_ier;

  always #5 clk = ~clk;

  always @(posedge clk) if (ap_start_o) start_cycles <= start_cycles + 1;

  custom_hls_ctrl_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_ARGS(NA), .ARG_WIDTH(ARGW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .control_axilite_awvalid(awvalid), .control_axilite_awready(awready), .control_axilite_awaddr(awaddr),
    .control_axilite_wvalid(wvalid), .control_axilite_wready(wready), .control_axilite_wdata(wdata),
    .control_axilite_wstrb(wstrb),
    .control_axilite_bvalid(bvalid), .control_axilite_bready(bready), .control_axilite_bresp(bresp),
    .control_axilite_arvalid(arvalid), .control_axilite_arready(arready), .control_axilite_araddr(araddr),
    .control_axilite_rvalid(rvalid), .control_axilite_rready(rready), .control_axilite_rdata(rdata),
    .control_axilite_rresp(rresp),
    .ap_start_o(ap_start_o), .ap_ready_i(ap_ready_i), .ap_done_i(ap_done_i), .ap_idle_i(ap_idle_i),
    .args_o(args_o), .interrupt_o(interrupt_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference register file: registers seen as plain storage, args as 64-bit words split in byte lanes.
  function automatic logic [31:0] m_read(input logic [AW-1:0] a, output logic [1:0] resp);
    int w;
    int idx;
    w = int'(a) & ~3;
    resp = 2'b00;
    if (w == 0) return 32'h4;
    if (w == 4) return {31'd0, m_gie};
    if (w == 8) return {30'd0, m_ier};
    if (w == 12) return 32'h0;
    idx = (w - 16) / 8;
    if (idx < NA) return ((w - 16) % 8 == 4) ? m_args[idx][63:32] : m_args[idx][31:0];
    resp = 2'b10;
    return 32'h0;
  endfunction

  function automatic logic [1:0] m_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int w;
    int idx;
    int base;
    w = int'(a) & ~3;
    if (w == 4) begin if (s[0]) m_gie = d[0]; return 2'b00; end
    if (w == 8) begin if (s[0]) m_ier = d[1:0]; return 2'b00; end
    idx = (w - 16) / 8;
    if (w >= 16 && idx < NA) begin
      base = ((w - 16) % 8 == 4) ? 32 : 0;
      for (int b = 0; b < 4; b++) if (s[b]) m_args[idx][base + b*8 +: 8] = d[b*8 +: 8];
      return 2'b00;
    end
    return 2'b10;
  endfunction

  task automatic axi_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                        input bit done_pulse, output logic [1:0] resp);
    int n;
    awvalid = 1'b1; awaddr = a; n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    chk("aw_hs", awready, 1);
    @(negedge clk); awvalid = 1'b0;
    wvalid = 1'b1; wdata = d; wstrb = s; n = 0;
    if (done_pulse) ap_done_i = 1'b1;
    while (!wready && n < 20) begin @(negedge clk); n++; end
    chk("w_hs", wready, 1);
    @(negedge clk); wvalid = 1'b0; ap_done_i = 1'b0; n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    chk("b_hs", bvalid, 1);
    resp = bresp; bready = 1'b1;
    @(negedge clk); bready = 1'b0;
  endtask

  task automatic axi_rd(input logic [AW-1:0] a, input bit done_pulse,
                        output logic [31:0] d, output logic [1:0] resp);
    int n;
    arvalid = 1'b1; araddr = a; n = 0;
    if (done_pulse) ap_done_i = 1'b1;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    chk("ar_hs", arready, 1);
    @(negedge clk); arvalid = 1'b0; ap_done_i = 1'b0; n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    chk("r_hs", rvalid, 1);
    d = rdata; resp = rresp; rready = 1'b1;
    @(negedge clk); rready = 1'b0;
  endtask

  task automatic pulse_ready();
    ap_ready_i = 1'b1;
    @(negedge clk);
    ap_ready_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, ed;
    logic [1:0] r, er;
    logic [AW-1:0] a;
    int snap;
    rst_i = 1'b1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    ap_ready_i = 0; ap_done_i = 0; ap_idle_i = 1;
    for (int i = 0; i < NA; i++) m_args[i] = '0;
    m_gie = 0; m_ier = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;

    chk("rst_awready", awready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_start", ap_start_o, 0);
    chk("rst_irq", interrupt_o, 0);
    chk("rst_args", |args_o, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resps", {bresp, rresp}, 0);
    for (int i = 0; i < 4 + 2*NA; i++) begin
      axi_rd(AW'(4*i), 0, d, r);
      chk("rst_reg", d, (i == 0) ? 32'h4 : 32'h0);
      chk("rst_reg_resp", r, 2'b00);
    end
    axi_rd(12'hFF0, 0, d, r);
    chk("unmapped_data", d, 0);
    chk("unmapped_resp", r, 2'b10);

    // Argument byte strobes
    axi_wr(12'h018, 32'hDEADBEEF, 4'hF, 0, r);
    axi_wr(12'h01C, 32'h12345678, 4'hF, 0, r);
    axi_wr(12'h018, 32'h000000AA, 4'h1, 0, r);
    chk("arg1_resp", r, 2'b00);
    chk("arg1_out", args_o[127:64], 64'h12345678DEADBEAA);
    axi_rd(12'h018, 0, d, r); chk("arg1_lo_rd", d, 32'hDEADBEAA);
    axi_rd(12'h01C, 0, d, r); chk("arg1_hi_rd", d, 32'h12345678);
    axi_wr(12'h028, 32'h1, 4'hF, 0, r); chk("past_args_wresp", r, 2'b10);

    // Single start: ready arrives in the fourth cycle of start
    snap = start_cycles;
    axi_wr(12'h000, 32'h1, 4'hF, 0, r);
    repeat (2) @(negedge clk);
    pulse_ready();
    repeat (3) @(negedge clk);
    chk("start_len", 64'(start_cycles - snap), 4);
    chk("start_cleared", ap_start_o, 0);
    axi_rd(12'h000, 0, d, r); chk("ctrl_ready_set", d, 32'hC);
    axi_rd(12'h000, 0, d, r); chk("ctrl_ready_clr", d, 32'h4);

    // Auto-restart keeps start asserted
    axi_wr(12'h000, 32'h81, 4'hF, 0, r);
    repeat (2) @(negedge clk);
    pulse_ready();
    repeat (3) @(negedge clk);
    chk("auto_start_held", ap_start_o, 1);
    axi_rd(12'h000, 0, d, r); chk("ctrl_auto_rd1", d, 32'h8D);
    axi_rd(12'h000, 0, d, r); chk("ctrl_auto_rd2", d, 32'h85);
    axi_wr(12'h000, 32'h0, 4'hF, 0, r);
    chk("start_write0_noeffect", ap_start_o, 1);
    pulse_ready();
    chk("auto_off_cleared", ap_start_o, 0);
    axi_rd(12'h000, 0, d, r); chk("ctrl_after_auto", d, 32'hC);

    // Done interrupt and clear-on-read
    axi_wr(12'h004, 32'h1, 4'hF, 0, r);
    axi_wr(12'h008, 32'h1, 4'hF, 0, r);
    chk("irq_idle", interrupt_o, 0);
    ap_done_i = 1'b1; @(negedge clk); ap_done_i = 1'b0;
    chk("irq_on_done", interrupt_o, 1);
    axi_rd(12'h000, 0, d, r); chk("ctrl_done_rd1", d, 32'h6);
    axi_rd(12'h000, 0, d, r); chk("ctrl_done_rd2", d, 32'h4);
    axi_rd(12'h00C, 0, d, r); chk("isr_done", d, 32'h1);
    axi_wr(12'h00C, 32'h1, 4'hF, 0, r);
    chk("irq_cleared", interrupt_o, 0);

    // Set events coincident with clear-on-read and toggle
    axi_rd(12'h000, 1, d, r); chk("ctrl_coinc_rd1", d, 32'h4);
    axi_rd(12'h000, 0, d, r); chk("ctrl_coinc_rd2", d, 32'h6);
    chk("irq_coinc", interrupt_o, 1);
    axi_wr(12'h00C, 32'h1, 4'hF, 1, r);
    axi_rd(12'h00C, 0, d, r); chk("isr_set_wins", d, 32'h1);
    axi_wr(12'h00C, 32'h1, 4'hF, 0, r);
    axi_rd(12'h00C, 0, d, r); chk("isr_toggled", d, 32'h0);

    // Reset while a write response is stalled
    ap_done_i = 1'b1; @(negedge clk); ap_done_i = 1'b0;
    chk("irq_before_rst", interrupt_o, 1);
    awvalid = 1'b1; awaddr = 12'h010; @(negedge clk); awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; @(negedge clk); wvalid = 1'b0;
    chk("stall_bvalid", bvalid, 1);
    rst_i = 1'b1; @(negedge clk);
    chk("rst_mid_bvalid", bvalid, 0);
    chk("rst_mid_awready", awready, 1);
    chk("rst_mid_args", |args_o, 0);
    chk("rst_mid_irq", interrupt_o, 0);
    chk("rst_mid_start", ap_start_o, 0);
    rst_i = 1'b0; @(negedge clk);
    axi_rd(12'h000, 0, d, r); chk("rst_mid_ctrl", d, 32'h4);
    axi_rd(12'h004, 0, d, r); chk("rst_mid_gie", d, 32'h0);

    // Random register traffic against the reference model
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: a = AW'($urandom_range(0, 15));
        1, 2: a = AW'(16 + $urandom_range(0, 8*NA + 7));
        default: a = AW'($urandom_range(48, 4095));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        if (a < 16) a[3:2] = 2'($urandom_range(1, 2));
        d = $urandom;
        wstrb = 4'($urandom_range(0, 15));
        er = m_write(a, d, wstrb);
        axi_wr(a, d, wstrb, 0, r);
        chk("rnd_wresp", r, er);
      end else begin
        ed = m_read(a, er);
        axi_rd(a, 0, d, r);
        chk("rnd_rdata", d, ed);
        chk("rnd_rresp", r, er);
      end
    end
    for (int i = 0; i < NA; i++) chk("rnd_args_out", args_o[i*ARGW +: ARGW], m_args[i]);
    chk("rnd_irq", interrupt_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
